// File: rtl/ahb_apb_bridge.sv
// AHB-to-APB3 bridge: terminates each AHB transfer and replays it as one APB3
// access, holding HREADY_OUT low until the completer answers.
module ahb_apb_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = 12
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic [1:0]            HRESP,
  output logic                  HREADY_OUT,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
  logic [1:0]              hresp_q, hresp_d;
  logic                    hready_q, hready_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;

  logic [ADDR_WIDTH-1:0]   idx;
  logic                    mapped;
  logic                    accept;
  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    unused_htrans0;

  // Handshakes: AHB address is taken when HREADY_OUT && HSEL && HTRANS[1] at a
  // rising edge; APB access ends at the edge where PENABLE && PREADY.
  assign unused_htrans0 = HTRANS[0];
  assign idx    = HADDR >> SEL_LSB;
  assign mapped = (idx < ADDR_WIDTH'(NUM_SLAVES));
  assign accept = hready_q && HSEL && HTRANS[1] &&
                  ((state_q == ST_IDLE) || (state_q == ST_ERR2));

  always_comb begin
    dec_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == ADDR_WIDTH'(i)) dec_sel[i] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    hrdata_d  = hrdata_q;
    hresp_d   = hresp_q;
    hready_d  = hready_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d  = ST_IDLE;
        hready_d = 1'b1;
        hresp_d  = RESP_OKAY;
        if (accept) begin
          hready_d = 1'b0;
          if (mapped) begin
            state_d  = ST_SETUP;
            paddr_d  = HADDR;
            pwrite_d = HWRITE;
            psel_d   = dec_sel;
          end else begin
            state_d = ST_ERR1;
            hresp_d = RESP_ERROR;
          end
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        // HWDATA belongs to the first data-phase cycle, which is this one.
        if (pwrite_q) pwdata_d = HWDATA;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          psel_d    = '0;
          penable_d = 1'b0;
          if (PSLVERR) begin
            state_d = ST_ERR1;
            hresp_d = RESP_ERROR;
          end else begin
            state_d  = ST_IDLE;
            hready_d = 1'b1;
            hresp_d  = RESP_OKAY;
            if (!pwrite_q) hrdata_d = PRDATA;
          end
        end
      end
      ST_ERR1: begin
        state_d  = ST_ERR2;
        hready_d = 1'b1;
        hresp_d  = RESP_ERROR;
      end
      default: begin
        state_d   = ST_IDLE;
        hready_d  = 1'b1;
        hresp_d   = RESP_OKAY;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      hrdata_q  <= '0;
      hresp_q   <= RESP_OKAY;
      hready_q  <= 1'b1;
      psel_q    <= '0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      hrdata_q  <= hrdata_d;
      hresp_q   <= hresp_d;
      hready_q  <= hready_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign HRDATA     = hrdata_q;
  assign HRESP      = hresp_q;
  assign HREADY_OUT = hready_q;
  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PADDR      = paddr_q;
  assign PWRITE     = pwrite_q;
  assign PWDATA     = pwdata_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/ahb_apb_bridge.md
Name: ahb_apb_bridge

Overview:
AHB slave that terminates transfers from the AHB master port and converts each into a single APB3 transfer. Sits directly downstream of the AHB interface: it drives the slave modport outputs (HRDATA, HRESP, HREADY_OUT) and is the only AHB slave in front of the APB peripheral bus. It decodes HADDR into a one-hot PSEL and inserts AHB wait states until the APB completer responds. It returns a two-cycle AHB ERROR on PSLVERR or on an unmapped address.

Parameters:
ADDR_WIDTH, 32, HADDR/PADDR width
DATA_WIDTH, 32, HWDATA/HRDATA/PWDATA/PRDATA width
NUM_SLAVES, 4, number of APB completers (PSEL width), 1..16
SEL_LSB, 12, lowest HADDR bit of slave index (4 KB window per slave)

Ports:
HCLK  in  1  clock, all logic rising-edge
HRESET  in  1  synchronous reset, active-high
HSEL  in  1  bridge selected
HADDR  in  ADDR_WIDTH  address-phase address
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE  in  1  1=write
HWDATA  in  DATA_WIDTH  write data, valid in the first data-phase cycle
HRDATA  out  DATA_WIDTH  read data, registered
HRESP  out  2  00 OKAY, 01 ERROR, registered
HREADY_OUT  out  1  transfer-done / address-accept, registered
PSEL  out  NUM_SLAVES  one-hot APB select
PENABLE  out  1  APB access phase
PADDR  out  ADDR_WIDTH  latched HADDR
PWRITE  out  1  latched HWRITE
PWDATA  out  DATA_WIDTH  latched HWDATA
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB completer ready
PSLVERR  in  1  APB error, valid with PREADY

Behaviour:
- Reset (HRESET=1 at an edge): state IDLE; HREADY_OUT=1, HRESP=00, HRDATA=0, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0. Reset mid-transfer abandons the APB access: PSEL/PENABLE are 0 the next cycle. Reset has priority over every other event.
- Accept: a transfer is sampled at an edge when HREADY_OUT=1 && HSEL && HTRANS[1]. It is sampled only in states IDLE or ERR2. BUSY and IDLE HTRANS are ignored and receive OKAY with no wait states.
- Decode: idx = HADDR >> SEL_LSB. A transfer is mapped if idx < NUM_SLAVES, else it is a decode error. No APB activity occurs on a decode error.
- States:
  - IDLE: HREADY_OUT=1, HRESP=00. On a mapped accept: latch PADDR/PWRITE, go to SETUP. On an unmapped accept: go to ERR1.
  - SETUP: PSEL[idx]=1, PENABLE=0, HREADY_OUT=0. PWDATA is captured from HWDATA at the edge entering SETUP+1, so it is valid during ACCESS. Writes take HWDATA in this cycle. Always go to ACCESS.
  - ACCESS: PSEL held, PENABLE=1, HREADY_OUT=0. Stay while PREADY=0; PADDR, PWRITE, PWDATA and PSEL are stable throughout. On PREADY=1 && !PSLVERR: capture PRDATA into HRDATA on reads; go to IDLE with HREADY_OUT=1, HRESP=00. On PREADY=1 && PSLVERR: go to ERR1. PSEL and PENABLE return to 0 on leaving ACCESS.
  - ERR1: HREADY_OUT=0, HRESP=01. Always go to ERR2.
  - ERR2: HREADY_OUT=1, HRESP=01. Accepts a new transfer exactly as IDLE does; otherwise go to IDLE.
- Latency:
  - Zero-wait APB transfer: address sampled at T0; SETUP T1; ACCESS T2; HREADY_OUT=1 at T3, so the data phase carries 2 wait states.
  - Each PREADY=0 cycle adds 1 wait state.
  - Decode error completes in 2 cycles (ERR1, ERR2).
- Back-to-back: a transfer presented while the prior data phase completes (HREADY_OUT=1) is accepted with no idle cycle between APB transfers' SETUP phases beyond the IDLE completion cycle.
- HRDATA holds its last value on writes and errors. PSEL is never multi-hot. PENABLE=1 only in ACCESS.
- SEQ is treated identically to NONSEQ; no burst optimisation.

Test Plan:
1. Reset → HREADY_OUT=1, HRESP=00, PSEL=0, PENABLE=0, HRDATA=0; assert HRESET while in ACCESS → PSEL=0 next cycle, state IDLE.
2. Write HADDR=0x0000_1004, HWDATA=0xDEADBEEF, PREADY tied 1 → PSEL=0010 at T1 and T2; PENABLE=1 at T2; PWDATA=0xDEADBEEF, PADDR=0x1004; HREADY_OUT=0 at T1–T2, 1 at T3, HRESP=00.
3. Read HADDR=0x0000_3000, PRDATA=0x12345678, PREADY low for 3 cycles → HREADY_OUT low for 5 cycles, then HRDATA=0x12345678 with HRESP=00.
4. Read HADDR=0x0000_5000 (idx 5 ≥ 4) → PSEL stays 0; HRESP=01 with HREADY_OUT=0, then HRESP=01 with HREADY_OUT=1; HRDATA unchanged.
5. Write HADDR=0x0000_2000, PSLVERR=1 with PREADY=1 → ERR1/ERR2 sequence; HRESP=00 again on the next IDLE.
6. Back-to-back NONSEQ write 0x0000 then read 0x1000, presented on the completion cycle; BUSY cycle inserted elsewhere → the second transfer reaches SETUP the cycle after completion; BUSY yields no PSEL activity.
